// File: rtl/led_pattern_ctrl_if.sv
// ----------------------------------------------------------------------------
// led_pattern_if : key inputs and display outputs of led_pattern_ctrl.
//   master : key source / display consumer (board glue or testbench)
//   slave  : the pattern controller itself
// ----------------------------------------------------------------------------
interface led_pattern_if #(
    parameter int WIDTH = 8
);
    logic             key_add;
    logic             key_sub;
    logic             key_shift_left;
    logic             key_shift_right;
    logic             key_mode;
    logic [WIDTH-1:0] led;
    logic [1:0]       mode;
    logic             step;

    modport master (
        output key_add, key_sub, key_shift_left, key_shift_right, key_mode,
        input  led, mode, step
    );

    modport slave (
        input  key_add, key_sub, key_shift_left, key_shift_right, key_mode,
        output led, mode, step
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// led_pattern_ctrl : key-driven LED pattern generator.
//   MANUAL    : add / sub / shift-left / shift-right on key rising edges
//   COUNT_UP  : led + 1 every TICK_DIV clocks
//   RUN_LEFT  : rotate left every TICK_DIV clocks
//   RUN_RIGHT : rotate right every TICK_DIV clocks
// key_mode rising edges cycle through the four modes.
//
// Build option: define LED_SATURATE_EN to make add / COUNT_UP hold at
// all-ones and sub hold at zero; without it they wrap modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic            clk,
    input  logic            reset,
    led_pattern_if.slave    bus
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        MANUAL    = 2'b00,
        COUNT_UP  = 2'b01,
        RUN_LEFT  = 2'b10,
        RUN_RIGHT = 2'b11
    } mode_t;

    // ------------------------------------------------------------------
    // Value arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] inc_val(input logic [WIDTH-1:0] v);
`ifdef LED_SATURATE_EN
        return (&v) ? v : v + WIDTH'(1);
`else
        return v + WIDTH'(1);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] dec_val(input logic [WIDTH-1:0] v);
`ifdef LED_SATURATE_EN
        return (v == '0) ? v : v - WIDTH'(1);
`else
        return v - WIDTH'(1);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            MANUAL:   r = COUNT_UP;
            COUNT_UP: r = RUN_LEFT;
            RUN_LEFT: r = RUN_RIGHT;
            default:  r = MANUAL;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage p1: one-cycle delayed key samples for edge detection
    // ------------------------------------------------------------------
    logic key_add_p1;
    logic key_sub_p1;
    logic key_shl_p1;
    logic key_shr_p1;
    logic key_mode_p1;

    // Delay each key by one cycle; cleared by reset so a key held across
    // reset release registers as a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_add_p1  <= 1'b0;
            key_sub_p1  <= 1'b0;
            key_shl_p1  <= 1'b0;
            key_shr_p1  <= 1'b0;
            key_mode_p1 <= 1'b0;
        end else begin
            key_add_p1  <= bus.key_add;
            key_sub_p1  <= bus.key_sub;
            key_shl_p1  <= bus.key_shift_left;
            key_shr_p1  <= bus.key_shift_right;
            key_mode_p1 <= bus.key_mode;
        end
    end

    logic add_edge;
    logic sub_edge;
    logic shl_edge;
    logic shr_edge;
    logic mode_edge;

    assign add_edge  = bus.key_add         & ~key_add_p1;
    assign sub_edge  = bus.key_sub         & ~key_sub_p1;
    assign shl_edge  = bus.key_shift_left  & ~key_shl_p1;
    assign shr_edge  = bus.key_shift_right & ~key_shr_p1;
    assign mode_edge = bus.key_mode        & ~key_mode_p1;

    // ------------------------------------------------------------------
    // Mode FSM, prescaler and registered display outputs
    // ------------------------------------------------------------------
    mode_t            mode_q;
    mode_t            mode_nxt;
    logic [WIDTH-1:0] led_q;
    logic             step_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    assign mode_nxt = next_mode(mode_q);
    assign tick     = (mode_q != MANUAL) && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Single state machine: a mode transition takes precedence over any
    // action in the same cycle (manual key or auto tick), restarts the
    // prescaler, and seeds the running-light modes with a lit bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MANUAL;
            led_q  <= '0;
            step_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            step_q <= 1'b0;
            if (mode_edge) begin
                mode_q <= mode_nxt;
                cnt_q  <= '0;
                if (((mode_nxt == RUN_LEFT) || (mode_nxt == RUN_RIGHT)) && (led_q == '0)) begin
                    led_q <= WIDTH'(1);
                end
            end else if (mode_q == MANUAL) begin
                cnt_q <= '0;
                if (add_edge) begin
                    led_q  <= inc_val(led_q);
                    step_q <= 1'b1;
                end else if (sub_edge) begin
                    led_q  <= dec_val(led_q);
                    step_q <= 1'b1;
                end else if (shl_edge) begin
                    led_q  <= led_q << 1;
                    step_q <= 1'b1;
                end else if (shr_edge) begin
                    led_q  <= led_q >> 1;
                    step_q <= 1'b1;
                end
            end else if (tick) begin
                cnt_q  <= '0;
                step_q <= 1'b1;
                case (mode_q)
                    COUNT_UP: led_q <= inc_val(led_q);
                    RUN_LEFT: led_q <= rot_left(led_q);
                    default:  led_q <= rot_right(led_q);
                endcase
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.mode = mode_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_pattern_ctrl : directed bench for led_pattern_ctrl (WIDTH=8,
// TICK_DIV=4). Expected values are hand-computed; LED_SATURATE_EN selects
// the add-at-all-ones expectation.
// ----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_ADD  = 5'b00001;
    localparam logic [4:0] K_SUB  = 5'b00010;
    localparam logic [4:0] K_SHL  = 5'b00100;
    localparam logic [4:0] K_SHR  = 5'b01000;
    localparam logic [4:0] K_MODE = 5'b10000;

`ifdef LED_SATURATE_EN
    localparam logic [7:0] ADD_AT_FF = 8'hFF;
`else
    localparam logic [7:0] ADD_AT_FF = 8'h00;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    led_pattern_if #(.WIDTH(WIDTH)) bus ();

    led_pattern_ctrl #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] k);
        bus.key_add         = k[0];
        bus.key_sub         = k[1];
        bus.key_shift_left  = k[2];
        bus.key_shift_right = k[3];
        bus.key_mode        = k[4];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(K_NONE);
        cyc(2);
        chk("reset_led",  bus.led,  8'h00);
        chk("reset_mode", bus.mode, 2'b00);
        chk("reset_step", bus.step, 1'b0);

        // key_add already high on first cycle after reset release, held 5 cycles
        reset = 1'b0;
        drive(K_ADD);
        cyc(1);
        chk("add_first_led",  bus.led,  8'h01);
        chk("add_first_step", bus.step, 1'b1);
        cyc(1);
        chk("add_held_step_gone", bus.step, 1'b0);
        cyc(3);
        chk("add_held_led",  bus.led,  8'h01);
        chk("add_held_step", bus.step, 1'b0);
        drive(K_NONE);
        cyc(1);

        // sub back to zero
        drive(K_SUB);
        cyc(1);
        chk("sub_led",  bus.led,  8'h00);
        chk("sub_step", bus.step, 1'b1);
        drive(K_NONE);
        cyc(1);

        // climb to all-ones, then add once more
        for (int i = 0; i < 255; i++) begin
            drive(K_ADD);
            cyc(1);
            drive(K_NONE);
            cyc(1);
        end
        chk("climb_ff", bus.led, 8'hFF);
        drive(K_ADD);
        cyc(1);
        chk("add_at_ff_led",  bus.led,  ADD_AT_FF);
        chk("add_at_ff_step", bus.step, 1'b1);
        drive(K_NONE);
        cyc(1);

        // build 0x10: reset, add, shift left x4
        reset = 1'b1;
        cyc(1);
        chk("reset2_led", bus.led, 8'h00);
        reset = 1'b0;
        drive(K_ADD);
        cyc(1);
        drive(K_NONE);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            drive(K_SHL);
            cyc(1);
            drive(K_NONE);
            cyc(1);
        end
        chk("build_10", bus.led, 8'h10);

        // add and sub together: add wins, sub discarded
        drive(K_ADD | K_SUB);
        cyc(1);
        chk("prio_add_sub_led",  bus.led,  8'h11);
        chk("prio_add_sub_step", bus.step, 1'b1);
        drive(K_NONE);
        cyc(1);
        chk("prio_sub_dropped", bus.led, 8'h11);

        // build 0x81: sub -> 0x10, shl x3 -> 0x80, add -> 0x81
        drive(K_SUB);
        cyc(1);
        drive(K_NONE);
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            drive(K_SHL);
            cyc(1);
            drive(K_NONE);
            cyc(1);
        end
        drive(K_ADD);
        cyc(1);
        drive(K_NONE);
        cyc(1);
        chk("build_81", bus.led, 8'h81);

        // logical shift left drops MSB, zero fill
        drive(K_SHL);
        cyc(1);
        chk("shl_81_led",  bus.led,  8'h02);
        chk("shl_81_step", bus.step, 1'b1);
        drive(K_NONE);
        cyc(1);
        drive(K_SHR);
        cyc(1);
        chk("shr_02", bus.led, 8'h01);
        drive(K_NONE);
        cyc(1);
        drive(K_SHL | K_SHR);
        cyc(1);
        chk("prio_shl_shr", bus.led, 8'h02);
        drive(K_NONE);
        cyc(1);

        // RUN_LEFT entry from led=0
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        drive(K_MODE);
        cyc(1);
        chk("mode_count_up", bus.mode, 2'b01);
        drive(K_NONE);
        cyc(1);
        drive(K_MODE);
        cyc(1);
        chk("mode_run_left", bus.mode, 2'b10);
        chk("run_left_load", bus.led,  8'h01);
        chk("run_left_load_nostep", bus.step, 1'b0);
        drive(K_NONE);
        cyc(3);
        chk("run_left_wait_led",  bus.led,  8'h01);
        chk("run_left_wait_step", bus.step, 1'b0);
        cyc(1);
        chk("run_left_02_led",  bus.led,  8'h02);
        chk("run_left_02_step", bus.step, 1'b1);
        cyc(4);
        chk("run_left_04", bus.led, 8'h04);
        cyc(20);
        chk("run_left_80", bus.led, 8'h80);
        cyc(4);
        chk("run_left_wrap_led",  bus.led,  8'h01);
        chk("run_left_wrap_step", bus.step, 1'b1);

        // RUN_RIGHT, then reset mid-run at 0x40
        drive(K_MODE);
        cyc(1);
        chk("mode_run_right", bus.mode, 2'b11);
        chk("run_right_entry_led", bus.led, 8'h01);
        drive(K_NONE);
        cyc(4);
        chk("run_right_wrap_led",  bus.led,  8'h80);
        chk("run_right_wrap_step", bus.step, 1'b1);
        cyc(4);
        chk("run_right_40", bus.led, 8'h40);
        reset = 1'b1;
        cyc(1);
        chk("reset_run_led",  bus.led,  8'h00);
        chk("reset_run_mode", bus.mode, 2'b00);
        chk("reset_run_step", bus.step, 1'b0);
        reset = 1'b0;

        // COUNT_UP: keys ignored, ticks, mode edge on tick cycle
        drive(K_MODE);
        cyc(1);
        drive(K_NONE);
        cyc(1);
        drive(K_ADD);
        cyc(1);
        chk("count_up_key_ignored_led",  bus.led,  8'h00);
        chk("count_up_key_ignored_step", bus.step, 1'b0);
        drive(K_NONE);
        cyc(1);
        cyc(1);
        chk("count_up_tick1_led",  bus.led,  8'h01);
        chk("count_up_tick1_step", bus.step, 1'b1);
        cyc(3);
        chk("count_up_pre_tick", bus.led, 8'h01);
        drive(K_MODE);
        cyc(1);
        chk("tick_mode_mode", bus.mode, 2'b10);
        chk("tick_mode_led",  bus.led,  8'h01);
        chk("tick_mode_step", bus.step, 1'b0);
        drive(K_NONE);
        cyc(3);
        chk("after_tick_mode_wait", bus.step, 1'b0);
        cyc(1);
        chk("after_tick_mode_step", bus.step, 1'b1);
        chk("after_tick_mode_led",  bus.led,  8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LED vector width, legal range 2..32.
REQ-002 SHALL have parameter TICK_DIV, default 1000, clk cycles per auto step, legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1, system clock; single clock domain, all state on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports key_add, key_sub, key_shift_left, key_shift_right, input, 1 each, synchronous level inputs, one action per rising edge.
REQ-006 SHALL have port key_mode, input, 1, advances mode on each rising edge.
REQ-007 SHALL have port led, output, WIDTH, registered display value.
REQ-008 SHALL have port mode, output, 2, registered state: 00 MANUAL, 01 COUNT_UP, 10 RUN_LEFT, 11 RUN_RIGHT.
REQ-009 SHALL have port step, output, 1, registered one-cycle pulse whenever led is written with a new action result.

Function
REQ-010 Each key SHALL be edge-detected against a one-cycle delayed copy; edge = key high now, low in the previous sample.
REQ-011 Edge detected at clock edge N SHALL update led and pulse step after edge N (1-cycle latency); a held key SHALL yield one action only.
REQ-012 State sequence on key_mode edge SHALL be MANUAL->COUNT_UP->RUN_LEFT->RUN_RIGHT->MANUAL.
REQ-013 In MANUAL, priority SHALL be add > sub > shift_left > shift_right; one action per cycle; lower-priority edges in that cycle are discarded.
REQ-014 MANUAL add/sub SHALL be modulo 2^WIDTH (see REQ-024); shifts SHALL be logical, zero fill.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 in non-MANUAL states, tick at TICK_DIV-1, then return to 0; held at 0 in MANUAL.
REQ-016 COUNT_UP SHALL apply led+1 on each tick.
REQ-017 RUN_LEFT / RUN_RIGHT SHALL rotate led by one bit left / right on each tick (MSB->LSB / LSB->MSB).
REQ-018 On entry into RUN_LEFT or RUN_RIGHT with led==0, led SHALL load 1 on the transition edge; otherwise led unchanged on transition.
REQ-019 Any mode transition SHALL clear prescaler to 0; key_mode edge coincident with tick: transition wins, step discarded.
REQ-020 In non-MANUAL states the four action keys SHALL be ignored, but their delay registers still update.
REQ-021 step SHALL pulse on every applied action, including writes leaving led unchanged (e.g. saturation); not on REQ-018 load.

Reset
REQ-022 reset high at a clock edge SHALL set led=0, mode=00, step=0, prescaler=0, all key delay registers=0; reset has priority over all other events.
REQ-023 A key already high on the first cycle after reset deassert SHALL count as a rising edge.

Configuration
REQ-024 Macro LED_SATURATE_EN: if defined, add SHALL hold at all-ones and sub at 0, including COUNT_UP (stays at all-ones); if undefined, add/sub/COUNT_UP SHALL wrap modulo 2^WIDTH.

Verification (WIDTH=8, TICK_DIV=4)
REQ-025 Reset, key_add high 5 cycles -> led=0x01 one cycle after first high, single step pulse, remains 0x01.
REQ-026 led=0xFF, key_add edge -> led=0x00 without macro; 0xFF with LED_SATURATE_EN, step pulses in both.
REQ-027 key_add and key_sub rising same cycle from 0x10 -> led=0x11; key_shift_left edge from 0x81 -> 0x02.
REQ-028 led=0, key_mode edges x2 -> RUN_LEFT, led=0x01, then 0x02, 0x04 every 4 cycles; from 0x80 rotates to 0x01.
REQ-029 COUNT_UP, key_mode edge in tick cycle -> mode=10, led unchanged, next step 4 cycles later.
REQ-030 reset asserted mid-RUN_RIGHT with led=0x40 -> next cycle led=0x00, mode=00, step=0.
